// File: rtl/rjc_pkg.sv
// rtl/rjc_pkg.sv - shared mode/direction encodings and cycle-length helper for the ring/Johnson counter
package rjc_pkg;

   localparam logic MODE_RING    = 1'b0;
   localparam logic MODE_JOHNSON = 1'b1;
   localparam logic DIR_FWD      = 1'b0;
   localparam logic DIR_REV      = 1'b1;

   // Number of distinct positions in one full cycle of the selected mode.
   function automatic int rjc_len(input logic mode, input int width);
      return (mode == MODE_JOHNSON) ? 2 * width : width;
   endfunction

endpackage

// File: rtl/ring_state_encoder.sv
// rtl/ring_state_encoder.sv - legality check and binary position of a ring or Johnson state word
module ring_state_encoder
   import rjc_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int IDXW  = $clog2(2 * WIDTH)
) (
   input  logic [WIDTH-1:0] state,
   input  logic             mode,
   output logic             legal,
   output logic [IDXW-1:0]  pos
);

   int   w_ones;
   int   w_ring_pos;
   int   w_trans;
   int   w_lead;
   int   w_trail;
   logic w_run_l;
   logic w_run_t;

   // Count set bits, adjacent-bit transitions, and the ones runs anchored at MSB and LSB.
   always_comb begin
      w_ones     = 0;
      w_ring_pos = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (state[i]) begin
            w_ones     = w_ones + 1;
            w_ring_pos = WIDTH - 1 - i;
         end
      end

      w_trans = 0;
      for (int i = 0; i < WIDTH - 1; i++) begin
         if (state[i] != state[i+1]) w_trans = w_trans + 1;
      end

      w_lead  = 0;
      w_run_l = 1'b1;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         w_run_l = w_run_l & state[i];
         if (w_run_l) w_lead = w_lead + 1;
      end

      w_trail = 0;
      w_run_t = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         w_run_t = w_run_t & state[i];
         if (w_run_t) w_trail = w_trail + 1;
      end

      if (mode == MODE_RING) begin
         legal = (w_ones == 1);
         pos   = IDXW'(w_ring_pos);
      end else begin
         // A Johnson word has its ones contiguous from one end: filling from MSB
         // covers positions 0..WIDTH, draining from MSB covers WIDTH+1..2*WIDTH-1.
         legal = (w_trans <= 1);
         if (state[WIDTH-1])
            pos = IDXW'(w_lead);
         else if (w_trail == 0)
            pos = '0;
         else
            pos = IDXW'(2 * WIDTH - w_trail);
      end
   end

endmodule

// File: rtl/ring_johnson_counter.sv
// rtl/ring_johnson_counter.sv - run-time selectable ring/Johnson counter with direction, load and self-correction
module ring_johnson_counter
   import rjc_pkg::*;
#(
   parameter int WIDTH = 4,
   localparam int IDXW = $clog2(2 * WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic [IDXW-1:0]  idx,
   output logic             wrap,
   output logic             err
);

   localparam logic [WIDTH-1:0] RING_RST = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] JOHN_RST = '0;

   logic [WIDTH-1:0] r_q;
   logic [IDXW-1:0]  r_idx;
   logic             r_wrap;
   logic             r_err;
   logic             r_mode_q;

   logic             w_load_legal;
   logic [IDXW-1:0]  w_load_pos;
   logic             w_q_legal;
   logic [IDXW-1:0]  w_q_pos;
   logic [IDXW-1:0]  w_last;
   logic [WIDTH-1:0] w_cur_rst;
   logic [WIDTH-1:0] w_new_rst;

   ring_state_encoder #(.WIDTH(WIDTH), .IDXW(IDXW)) u_enc_load (
      .state (load_val),
      .mode  (r_mode_q),
      .legal (w_load_legal),
      .pos   (w_load_pos)
   );

   // Checks the live state so a corrupted word is replaced rather than shifted.
   ring_state_encoder #(.WIDTH(WIDTH), .IDXW(IDXW)) u_enc_q (
      .state (r_q),
      .mode  (r_mode_q),
      .legal (w_q_legal),
      .pos   (w_q_pos)
   );

   assign w_last    = IDXW'(rjc_len(r_mode_q, WIDTH) - 1);
   assign w_cur_rst = (r_mode_q == MODE_JOHNSON) ? JOHN_RST : RING_RST;
   assign w_new_rst = (mode == MODE_JOHNSON) ? JOHN_RST : RING_RST;

   // Next-state selection in priority order: reset, mode change, load, step, hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode_q <= mode;
         r_q      <= w_new_rst;
         r_idx    <= '0;
         r_wrap   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_wrap <= 1'b0;
         r_err  <= 1'b0;
         if (mode != r_mode_q) begin
            r_mode_q <= mode;
            r_q      <= w_new_rst;
            r_idx    <= '0;
         end else if (load) begin
            if (w_load_legal) begin
               r_q   <= load_val;
               r_idx <= w_load_pos;
            end else begin
               r_q   <= w_cur_rst;
               r_idx <= '0;
               r_err <= 1'b1;
            end
         end else if (en) begin
            if (!w_q_legal) begin
               r_q   <= w_cur_rst;
               r_idx <= '0;
               r_err <= 1'b1;
            end else if (dir == DIR_FWD) begin
               if (r_mode_q == MODE_JOHNSON) r_q <= {~r_q[0], r_q[WIDTH-1:1]};
               else                          r_q <= {r_q[0], r_q[WIDTH-1:1]};
               r_idx  <= (r_idx == w_last) ? '0 : r_idx + IDXW'(1);
               r_wrap <= (r_idx == w_last);
            end else begin
               if (r_mode_q == MODE_JOHNSON) r_q <= {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
               else                          r_q <= {r_q[WIDTH-2:0], r_q[WIDTH-1]};
               r_idx  <= (r_idx == '0) ? w_last : r_idx - IDXW'(1);
               r_wrap <= (r_idx == '0);
            end
         end
      end
   end

   assign q    = r_q;
   assign idx  = r_idx;
   assign wrap = r_wrap;
   assign err  = r_err;

endmodule

// File: tb/tb_ring_johnson_counter.sv
// tb/tb_ring_johnson_counter.sv - self-checking bench for ring_johnson_counter (WIDTH=4)
module tb_ring_johnson_counter;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         en = 1'b0;
   logic         mode = 1'b0;
   logic         dir = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] q;
   logic [2:0]   idx;
   logic         wrap;
   logic         err;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model: position in the cycle plus a flag for a corrupted word.
   logic         m_valid = 1'b0;
   logic         m_mode = 1'b0;
   int           m_pos = 0;
   logic         m_bad = 1'b0;
   logic [W-1:0] m_badq = '0;
   logic         m_wrap = 1'b0;
   logic         m_err = 1'b0;

   ring_johnson_counter #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
      .load(load), .load_val(load_val),
      .q(q), .idx(idx), .wrap(wrap), .err(err)
   );

   always #5 clk = ~clk;

   function automatic int mlen(input logic md);
      return md ? 2 * W : W;
   endfunction

   // Pattern shown at position p: ring has a single one walking down from the MSB;
   // Johnson fills with ones from the MSB for p<=W, then drains leaving 2W-p low ones.
   function automatic logic [W-1:0] pat(input logic md, input int p);
      int v;
      if (!md) v = 1 << (W - 1 - p);
      else if (p <= W) v = ((1 << p) - 1) << (W - p);
      else v = (1 << (2 * W - p)) - 1;
      return W'(v);
   endfunction

   function automatic int find_pos(input logic md, input logic [W-1:0] v);
      for (int p = 0; p < mlen(md); p++) if (pat(md, p) == v) return p;
      return -1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: actual %0h required %0h", nm, $time, act, exp);
      end
   endtask

   // Model update on each edge, then compare outputs just after the edge.
   always @(posedge clk) begin
      int lp;
      m_wrap = 1'b0;
      m_err  = 1'b0;
      if (rst) begin
         m_valid = 1'b1; m_mode = mode; m_pos = 0; m_bad = 1'b0;
      end else if (mode != m_mode) begin
         m_mode = mode; m_pos = 0; m_bad = 1'b0;
      end else if (load) begin
         lp = find_pos(m_mode, load_val);
         m_bad = 1'b0;
         if (lp >= 0) m_pos = lp;
         else begin m_pos = 0; m_err = 1'b1; end
      end else if (en) begin
         if (m_bad) begin
            m_bad = 1'b0; m_pos = 0; m_err = 1'b1;
         end else if (!dir) begin
            m_wrap = (m_pos == mlen(m_mode) - 1);
            m_pos  = (m_pos + 1) % mlen(m_mode);
         end else begin
            m_wrap = (m_pos == 0);
            m_pos  = (m_pos + mlen(m_mode) - 1) % mlen(m_mode);
         end
      end
      #1;
      if (m_valid) begin
         chk("model_q", 32'(q), 32'(m_bad ? m_badq : pat(m_mode, m_pos)));
         chk("model_idx", 32'(idx), 32'(m_pos));
         chk("model_wrap", 32'(wrap), 32'(m_wrap));
         chk("model_err", 32'(err), 32'(m_err));
      end
   end

   task automatic cyc(input logic r, input logic e, input logic m, input logic d,
                      input logic l, input logic [W-1:0] v);
      rst = r; en = e; mode = m; dir = d; load = l; load_val = v;
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [W-1:0] ring_exp [4];
   logic [W-1:0] john_exp [8];

   initial begin
      ring_exp[0] = 4'b0100; ring_exp[1] = 4'b0010; ring_exp[2] = 4'b0001; ring_exp[3] = 4'b1000;
      john_exp[0] = 4'b1000; john_exp[1] = 4'b1100; john_exp[2] = 4'b1110; john_exp[3] = 4'b1111;
      john_exp[4] = 4'b0111; john_exp[5] = 4'b0011; john_exp[6] = 4'b0001; john_exp[7] = 4'b0000;

      @(negedge clk);

      // Ring forward from reset
      cyc(1, 0, 0, 0, 0, 4'h0);
      chk("rst_ring_q", 32'(q), 32'h8);
      chk("rst_ring_idx", 32'(idx), 32'd0);
      chk("rst_ring_err", 32'(err), 32'd0);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, 0, 0, 0, 4'h0);
         chk("ring_fwd_q", 32'(q), 32'(ring_exp[i]));
         chk("ring_fwd_idx", 32'(idx), 32'((i + 1) % 4));
         chk("ring_fwd_wrap", 32'(wrap), 32'(i == 3));
      end

      // Johnson forward from reset
      cyc(1, 0, 1, 0, 0, 4'h0);
      chk("rst_john_q", 32'(q), 32'h0);
      for (int i = 0; i < 8; i++) begin
         cyc(0, 1, 1, 0, 0, 4'h0);
         chk("john_fwd_q", 32'(q), 32'(john_exp[i]));
         chk("john_fwd_idx", 32'(idx), 32'((i + 1) % 8));
         chk("john_fwd_wrap", 32'(wrap), 32'(i == 7));
      end

      // Reverse step from reset in both modes
      cyc(1, 0, 0, 1, 0, 4'h0);
      cyc(0, 1, 0, 1, 0, 4'h0);
      chk("ring_rev_q", 32'(q), 32'h1);
      chk("ring_rev_idx", 32'(idx), 32'd3);
      chk("ring_rev_wrap", 32'(wrap), 32'd1);
      cyc(1, 0, 1, 1, 0, 4'h0);
      cyc(0, 1, 1, 1, 0, 4'h0);
      chk("john_rev_q", 32'(q), 32'h1);
      chk("john_rev_idx", 32'(idx), 32'd7);
      chk("john_rev_wrap", 32'(wrap), 32'd1);
      cyc(0, 1, 1, 1, 0, 4'h0);
      chk("john_rev2_q", 32'(q), 32'h3);

      // Loads, legal and illegal
      cyc(1, 0, 0, 0, 0, 4'h0);
      cyc(0, 0, 0, 0, 1, 4'b0010);
      chk("ring_load_q", 32'(q), 32'h2);
      chk("ring_load_idx", 32'(idx), 32'd2);
      chk("ring_load_err", 32'(err), 32'd0);
      cyc(0, 0, 0, 0, 1, 4'b0110);
      chk("ring_bad_load_q", 32'(q), 32'h8);
      chk("ring_bad_load_idx", 32'(idx), 32'd0);
      chk("ring_bad_load_err", 32'(err), 32'd1);
      cyc(0, 0, 0, 0, 0, 4'h0);
      chk("err_one_cycle", 32'(err), 32'd0);
      cyc(1, 0, 1, 0, 0, 4'h0);
      cyc(0, 0, 1, 0, 1, 4'b0011);
      chk("john_load_idx", 32'(idx), 32'd6);
      chk("john_load_q", 32'(q), 32'h3);
      cyc(0, 0, 1, 0, 1, 4'b0110);
      chk("john_bad_load_q", 32'(q), 32'h0);
      chk("john_bad_load_err", 32'(err), 32'd1);

      // Simultaneous events
      cyc(1, 0, 0, 0, 0, 4'h0);
      cyc(0, 1, 0, 0, 1, 4'b0001);
      chk("load_beats_en_q", 32'(q), 32'h1);
      chk("load_beats_en_idx", 32'(idx), 32'd3);
      cyc(1, 0, 0, 0, 1, 4'b0010);
      chk("rst_beats_load_q", 32'(q), 32'h8);
      cyc(0, 1, 0, 0, 0, 4'h0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 0, 4'h0);
         chk("hold_q", 32'(q), 32'h4);
         chk("hold_idx", 32'(idx), 32'd1);
         chk("hold_wrap", 32'(wrap), 32'd0);
      end

      // Mode change overrides load and step
      cyc(1, 0, 0, 0, 0, 4'h0);
      cyc(0, 1, 0, 0, 0, 4'h0);
      chk("pre_mode_q", 32'(q), 32'h4);
      cyc(0, 1, 1, 0, 1, 4'b0010);
      chk("mode_chg_q", 32'(q), 32'h0);
      chk("mode_chg_idx", 32'(idx), 32'd0);
      chk("mode_chg_wrap", 32'(wrap), 32'd0);
      chk("mode_chg_err", 32'(err), 32'd0);

      // Corrupted state is replaced on the next step
      cyc(1, 0, 0, 0, 0, 4'h0);
      dut.r_q = 4'b0110;
      m_badq  = 4'b0110;
      m_bad   = 1'b1;
      cyc(0, 0, 0, 0, 0, 4'h0);
      cyc(0, 1, 0, 0, 0, 4'h0);
      chk("seu_fix_q", 32'(q), 32'h8);
      chk("seu_fix_err", 32'(err), 32'd1);
      chk("seu_fix_wrap", 32'(wrap), 32'd0);

      // Mixed stream checked by the model
      for (int i = 0; i < 200; i++) begin
         cyc(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 3) != 0),
             (i >= 100), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
